// File: rtl/jtopl_pkg.sv
// Shared vibrato constants and the pitch-offset rule for the OPL vibrato unit.
// The rule lives here so every consumer sees one definition of the depth and
// position table.
package jtopl_pkg;

  // Vibrato position counter width (8 positions per LFO cycle).
  localparam int unsigned VibPosW = 3;
  // Signed pitch offset width, range -7..+7.
  localparam int unsigned VibOffW = 4;

  // OPL2 defaults: 1024 samples per vibrato step, 18 slots per frame.
  localparam int unsigned DefDiv   = 10;
  localparam int unsigned DefSlots = 18;

  // Signed offset for one slot.
  // r   : top three bits of fnum
  // pos : vibrato position; pos[2] is the sign, pos[1:0] selects the magnitude
  // dep : 1 = 14 cent depth, 0 = 7 cent depth (one extra halving)
  function automatic logic signed [VibOffW-1:0] vib_offset(input logic [2:0]         r,
                                                           input logic [VibPosW-1:0] pos,
                                                           input logic               dep);
    logic [2:0] mag;
    unique case (pos[1:0])
      2'd0:    mag = 3'd0;
      2'd2:    mag = r;
      default: mag = r >> 1;
    endcase
    if (!dep) begin
      mag = mag >> 1;
    end
    if (pos[2]) begin
      vib_offset = -$signed({1'b0, mag});
    end else begin
      vib_offset = $signed({1'b0, mag});
    end
  endfunction

endpackage

// File: rtl/jtopl_vib_lfo.sv
// Vibrato LFO: a DIV-bit prescaler counting frame starts (cen & zero) and a
// 3-bit position counter advanced on each prescaler carry.
// Optional macro JTOPL_VIB_TEST_EN adds test_fast, which advances the
// position on every frame start and freezes the prescaler.
module jtopl_vib_lfo
  import jtopl_pkg::*;
#(
  parameter int unsigned DIV = DefDiv
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  input  logic               zero,
`ifdef JTOPL_VIB_TEST_EN
  input  logic               test_fast,
`endif
  output logic [VibPosW-1:0] vib_pos
);

  logic [DIV-1:0]     presc_q, presc_d;
  logic [VibPosW-1:0] pos_q, pos_d;
  logic               pos_step;
  logic               fast;

`ifdef JTOPL_VIB_TEST_EN
  assign fast = test_fast;
`else
  assign fast = 1'b0;
`endif

  // Next-state: prescaler counts frame starts; its carry (or test_fast) steps the position.
  always_comb begin
    presc_d  = presc_q;
    pos_d    = pos_q;
    pos_step = 1'b0;
    if (cen && zero) begin
      if (fast) begin
        pos_step = 1'b1;
      end else begin
        presc_d  = presc_q + 1'b1;
        pos_step = &presc_q;
      end
    end
    if (pos_step) begin
      // Wraps 7 -> 0 naturally.
      pos_d = pos_q + 1'b1;
    end
  end

  // State registers with synchronous reset taking priority over cen.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      pos_q   <= '0;
    end else begin
      presc_q <= presc_d;
      pos_q   <= pos_d;
    end
  end

  assign vib_pos = pos_q;

endmodule

// File: rtl/jtopl_vib.sv
// Time-multiplexed vibrato stage: one slot per cen, adds a registered signed
// pitch offset to fnum and hands the result to the phase generator one cen later.
// Optional macro JTOPL_VIB_TEST_EN exposes test_fast (LFO speed-up).
module jtopl_vib
  import jtopl_pkg::*;
#(
  parameter int unsigned FW    = 10,
  parameter int unsigned DIV   = DefDiv,
  parameter int unsigned SLOTS = DefSlots
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cen,
  input  logic                      zero,
`ifdef JTOPL_VIB_TEST_EN
  input  logic                      test_fast,
`endif
  input  logic [FW-1:0]             fnum,
  input  logic                      vib_dep,
  input  logic                      viben,
  output logic [VibPosW-1:0]        vib_pos,
  output logic [4:0]                slot,
  output logic signed [VibOffW-1:0] pm_offset,
  output logic [FW-1:0]             fnum_mod
);

  localparam logic [4:0] SlotLast = 5'(SLOTS - 1);

  logic [4:0]                slot_q, slot_d;
  logic signed [VibOffW-1:0] off_q, off_d;
  logic [FW-1:0]             fmod_q, fmod_d;
  logic [VibPosW-1:0]        lfo_pos;

  jtopl_vib_lfo #(
    .DIV (DIV)
  ) u_lfo (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .zero      (zero),
`ifdef JTOPL_VIB_TEST_EN
    .test_fast (test_fast),
`endif
    .vib_pos   (lfo_pos)
  );

  // Offset and modulated fnum from current inputs. lfo_pos is the pre-increment
  // value, so slot 0 of a frame still sees the old vibrato position.
  always_comb begin
    off_d = '0;
    if (viben) begin
      off_d = vib_offset(fnum[FW-1:FW-3], lfo_pos, vib_dep);
    end
    // Sign-extend the offset; the sum is taken modulo 2^FW.
    fmod_d = fnum + {{(FW - VibOffW){off_d[VibOffW-1]}}, off_d};
  end

  // Slot sequencer: restart on frame start, otherwise count up and stick at the last slot.
  always_comb begin
    slot_d = slot_q;
    if (cen) begin
      if (zero) begin
        slot_d = '0;
      end else if (slot_q != SlotLast) begin
        slot_d = slot_q + 1'b1;
      end
    end
  end

  // Output registers: load on cen, hold otherwise; reset wins over cen.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
      off_q  <= '0;
      fmod_q <= '0;
    end else begin
      slot_q <= slot_d;
      if (cen) begin
        off_q  <= off_d;
        fmod_q <= fmod_d;
      end
    end
  end

  assign vib_pos   = lfo_pos;
  assign slot      = slot_q;
  assign pm_offset = off_q;
  assign fnum_mod  = fmod_q;

endmodule

// File: tb/tb_jtopl_vib.sv
// Randomised bench for jtopl_vib against a frame/zero-counting reference model.
module tb_jtopl_vib;
  import jtopl_pkg::*;

  localparam int FW    = 10;
  localparam int SLOTS = 18;
  localparam int DIV   = 10;
  localparam int Steps = 1 << DIV;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cen = 1'b0;
  logic                zero = 1'b0;
  logic [FW-1:0]       fnum = '0;
  logic                vib_dep = 1'b0;
  logic                viben = 1'b0;
  logic [2:0]          vib_pos;
  logic [4:0]          slot;
  logic signed [3:0]   pm_offset;
  logic [FW-1:0]       fnum_mod;
`ifdef JTOPL_VIB_TEST_EN
  logic                test_fast = 1'b0;
`endif

  always #5 clk = ~clk;

  jtopl_vib #(
    .FW    (FW),
    .DIV   (DIV),
    .SLOTS (SLOTS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .zero      (zero),
`ifdef JTOPL_VIB_TEST_EN
    .test_fast (test_fast),
`endif
    .fnum      (fnum),
    .vib_dep   (vib_dep),
    .viben     (viben),
    .vib_pos   (vib_pos),
    .slot      (slot),
    .pm_offset (pm_offset),
    .fnum_mod  (fnum_mod)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: position, zeros seen since last step, slot, outputs.
  int m_pos  = 0;
  int m_zc   = 0;
  int m_slot = 0;
  int m_off  = 0;
  int m_fmod = 0;

  int sweep_tab[8] = '{0, 3, 7, 3, 0, -3, -7, -3};

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Offset from the written rule: magnitude from top 3 fnum bits, halved on odd
  // positions and again on shallow depth, negated in the second half-cycle.
  function automatic int ref_offset(int f, int pos, int dep, int en);
    int r;
    int mag;
    r = f >> (FW - 3);
    if (pos % 4 == 0) mag = 0;
    else if (pos % 4 == 2) mag = r;
    else mag = r / 2;
    if (dep == 0) mag = mag / 2;
    if (en == 0) return 0;
    return (pos >= 4) ? -mag : mag;
  endfunction

  function automatic logic [FW-1:0] rnd_fnum();
    return FW'($urandom_range(1016, 0));
  endfunction

  task automatic tick(input logic c, input logic z, input logic [FW-1:0] f, input logic d,
                      input logic v, input logic r);
    int sum;
    @(negedge clk);
    cen = c; zero = z; fnum = f; vib_dep = d; viben = v; rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      m_pos = 0; m_zc = 0; m_slot = 0; m_off = 0; m_fmod = 0;
    end else if (c) begin
      m_off = ref_offset(int'(f), m_pos, int'(d), int'(v));
      sum   = int'(f) + m_off;
      assert (sum >= 0 && sum < (1 << FW)) else $error("fnum offset out of range %0d", sum);
      m_fmod = sum % (1 << FW);
      m_slot = z ? 0 : ((m_slot + 1 > SLOTS - 1) ? SLOTS - 1 : m_slot + 1);
      if (z) begin
        m_zc++;
        if (m_zc == Steps) begin
          m_zc  = 0;
          m_pos = (m_pos + 1) % 8;
        end
      end
    end
    check_eq("vib_pos", int'(vib_pos), m_pos);
    check_eq("slot", int'(slot), m_slot);
    check_eq("pm_offset", int'(pm_offset), m_off);
    check_eq("fnum_mod", int'(fnum_mod), m_fmod);
  endtask

  task automatic tick_idle();
    tick(1'b0, 1'($urandom_range(1, 0)), rnd_fnum(), 1'($urandom_range(1, 0)),
         1'($urandom_range(1, 0)), 1'b0);
  endtask

  task automatic tick_rnd(input logic z);
    tick(1'b1, z, rnd_fnum(), 1'($urandom_range(1, 0)), 1'($urandom_range(3, 0) != 0), 1'b0);
  endtask

  initial begin
    int len;
    logic [FW-1:0] f;

    // Reset, with cen toggling to confirm reset wins.
    tick(1'b1, 1'b1, rnd_fnum(), 1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b0, rnd_fnum(), 1'b1, 1'b1, 1'b1);
    check_eq("reset_off", int'(pm_offset), 0);
    check_eq("reset_fmod", int'(fnum_mod), 0);

    // Phase A: normal frames with random gaps; some long frames to hit slot saturation.
    for (int fr = 0; fr < Steps; fr++) begin
      len = (fr % 50 == 7) ? SLOTS + 3 : SLOTS;
      for (int s = 0; s < len; s++) begin
        if ($urandom_range(7, 0) == 0) tick_idle();
        if (fr == Steps - 1 && s < 2) begin
          if (s == 0) check_eq("step_pos_before", int'(vib_pos), 0);
          tick(1'b1, s == 0, 10'h380, 1'b1, 1'b1, 1'b0);
          if (s == 0) begin
            check_eq("step_pos_after", int'(vib_pos), 1);
            check_eq("step_slot0_off", int'(pm_offset), 0);
          end else begin
            check_eq("step_slot1_off", int'(pm_offset), 3);
          end
        end else begin
          tick_rnd(s == 0);
        end
      end
    end

    // Phase B: one-slot frames to advance the LFO quickly up to position 5.
    for (int i = 0; i < 4 * Steps; i++) begin
      if ($urandom_range(7, 0) == 0) tick_idle();
      tick_rnd(1'b1);
    end
    check_eq("pre_rst_pos", int'(vib_pos), 5);
    for (int s = 0; s < 10; s++) tick_rnd(s == 0);
    check_eq("pre_rst_slot", int'(slot), 9);

    // Mid-frame reset coinciding with cen & zero, then a cen=0 gap.
    tick(1'b1, 1'b1, 10'h380, 1'b1, 1'b1, 1'b1);
    check_eq("rst_pos", int'(vib_pos), 0);
    check_eq("rst_slot", int'(slot), 0);
    check_eq("rst_off", int'(pm_offset), 0);
    check_eq("rst_fmod", int'(fnum_mod), 0);
    for (int i = 0; i < 4; i++) tick_idle();
    check_eq("gap_fmod", int'(fnum_mod), 0);

    // Phase C: full LFO cycle with directed checks at each position.
    for (int i = 0; i < 8 * Steps + 20; i++) begin
      if ($urandom_range(7, 0) == 0) tick_idle();
      if (m_zc == 512) begin
        len = m_pos;
        tick(1'b1, 1'b1, 10'h380, 1'b1, 1'b1, 1'b0);
        check_eq("sweep_off", int'(pm_offset), sweep_tab[len]);
        check_eq("sweep_fmod", int'(fnum_mod), 'h380 + sweep_tab[len]);
      end else if (m_zc == 600 && (m_pos == 2 || m_pos == 6)) begin
        len = m_pos;
        tick(1'b1, 1'b1, 10'h380, 1'b0, 1'b1, 1'b0);
        check_eq("shallow_off", int'(pm_offset), (len == 2) ? 3 : -3);
        check_eq("shallow_fmod", int'(fnum_mod), (len == 2) ? 'h383 : 'h37D);
      end else if (m_zc == 700) begin
        f = rnd_fnum();
        tick(1'b1, 1'b1, f, 1'($urandom_range(1, 0)), 1'b0, 1'b0);
        check_eq("noviben_off", int'(pm_offset), 0);
        check_eq("noviben_fmod", int'(fnum_mod), int'(f));
      end else begin
        tick_rnd(1'b1);
      end
    end
    check_eq("wrap_pos", int'(vib_pos), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
